// File: rtl/lfsr_range_rng.sv
// XNOR Fibonacci LFSR with seed load and lock-up recovery, plus a request/response
// range unit that returns a value in [0, max_val] by mask-and-reject sampling.
module lfsr_range_rng #(
  parameter int                 WIDTH     = 10,
  parameter logic [WIDTH-1:0]   TAPS      = 10'b0000001001,
  parameter int                 OUT_W     = 8,
  parameter int                 MAX_TRIES = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic             lockup,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] max_val,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [OUT_W-1:0] rnd_out
);

  localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, HOLD} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic             lockup_q, lockup_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [OUT_W-1:0] max_q, max_d;
  logic [OUT_W-1:0] mask_q, mask_d;
  logic [OUT_W-1:0] rnd_q, rnd_d;

  logic             fb;
  logic [WIDTH-1:0] lfsr_next;
  logic [OUT_W-1:0] req_mask;
  logic [OUT_W-1:0] cand;
  logic             advance;

  assign fb        = ~^(state_q & TAPS);
  assign lfsr_next = {fb, state_q[WIDTH-1:1]};
  assign cand      = state_q[OUT_W-1:0] & mask_q;

  // Smear the bound rightwards: smallest all-ones mask covering max_val (0 for 0).
  always_comb begin
    req_mask = max_val;
    for (int i = 1; i < OUT_W; i = i * 2) begin
      req_mask = req_mask | (req_mask >> i);
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    fsm_d   = fsm_q;
    tries_d = tries_q;
    max_d   = max_q;
    mask_d  = mask_q;
    rnd_d   = rnd_q;
    advance = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (req_valid) begin
          max_d   = max_val;
          mask_d  = req_mask;
          tries_d = '0;
          fsm_d   = SAMPLE;
        end
      end
      SAMPLE: begin
        advance = 1'b1;
        if (cand <= max_q) begin
          rnd_d = cand;
          fsm_d = HOLD;
        end else if (tries_q == LAST_TRY) begin
          // Dropping the top mask bit guarantees a value strictly below the bound.
          rnd_d = cand & (mask_q >> 1);
          fsm_d = HOLD;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
      HOLD: begin
        if (rnd_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    lockup_d = 1'b0;
    if (seed_load) begin
      state_d = seed;
    end else if (state_q == '1) begin
      state_d  = '0;
      lockup_d = 1'b1;
    end else if (enable || advance) begin
      state_d = lfsr_next;
    end else begin
      state_d = state_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      lockup_q <= 1'b0;
      tries_q  <= '0;
      max_q    <= '0;
      mask_q   <= '0;
      rnd_q    <= '0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      lockup_q <= lockup_d;
      tries_q  <= tries_d;
      max_q    <= max_d;
      mask_q   <= mask_d;
      rnd_q    <= rnd_d;
    end
  end

  assign state     = state_q;
  assign lockup    = lockup_q;
  assign req_ready = (fsm_q == IDLE);
  assign rnd_valid = (fsm_q == HOLD);
  assign rnd_out   = rnd_q;

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Self-checking bench for lfsr_range_rng: table-driven LFSR vectors, hand-written
// range-unit corner cases and randomized traffic against a transaction-level model.
module tb_lfsr_range_rng;

  localparam int         WIDTH     = 10;
  localparam int         OUT_W     = 8;
  localparam int         MAX_TRIES = 4;
  localparam logic [9:0] TAPS_TB   = 10'b0000001001;
  localparam int         ALL1      = 1023;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             enable = 1'b0;
  logic             seed_load = 1'b0;
  logic [WIDTH-1:0] seed = '0;
  logic [WIDTH-1:0] state;
  logic             lockup;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [OUT_W-1:0] max_val = '0;
  logic             rnd_valid;
  logic             rnd_ready = 1'b0;
  logic [OUT_W-1:0] rnd_out;

  int checks = 0;
  int failures = 0;

  lfsr_range_rng #(.WIDTH(WIDTH), .TAPS(TAPS_TB), .OUT_W(OUT_W), .MAX_TRIES(MAX_TRIES)) dut (
    .Clock(Clock), .Reset(Reset), .enable(enable), .seed_load(seed_load), .seed(seed),
    .state(state), .lockup(lockup), .req_valid(req_valid), .req_ready(req_ready),
    .max_val(max_val), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_out(rnd_out)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rst;
    logic       en;
    logic       ld;
    logic [9:0] sd;
    logic [9:0] exp_state;
    logic       exp_lock;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, en, ld, input logic [9:0] sd, es, input logic el);
    vec_t v;
    v.rst = rst; v.en = en; v.ld = ld; v.sd = sd; v.exp_state = es; v.exp_lock = el;
    return v;
  endfunction

  // Shift right, new MSB is 1 when the tapped bits hold an even number of ones.
  function automatic int lfsr_next(input int s);
    int ones = 0;
    for (int i = 0; i < WIDTH; i++) if (TAPS_TB[i] && ((s >> i) & 1) == 1) ones++;
    return (s >> 1) + ((ones % 2 == 0) ? 512 : 0);
  endfunction

  function automatic int step(input int s, input bit adv, output bit lk);
    lk = 0;
    if (s == ALL1) begin
      lk = 1;
      return 0;
    end
    return adv ? lfsr_next(s) : s;
  endfunction

  // Whole request in one go: result, number of sample cycles, state afterwards.
  task automatic model_range(input int s0, input int m, output int r, output int n, output int s_out);
    int mask = 0;
    int s = s0;
    int cand;
    bit lk;
    r = 0;
    n = 0;
    while (mask < m) mask = mask * 2 + 1;
    for (int t = 0; t < MAX_TRIES; t++) begin
      cand = s & mask;
      s = step(s, 1, lk);
      n = t + 1;
      if (cand <= m) begin
        r = cand;
        break;
      end
      if (t == MAX_TRIES - 1) r = cand & (mask >> 1);
    end
    s_out = s;
  endtask

  task automatic do_request(input logic [7:0] m, output logic [7:0] r, output int n);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    max_val   = m;
    tick();
    req_valid = 1'b0;
    check("req_ready_busy", req_ready, 0);
    max_val = ~m;
    n = 0;
    while (!rnd_valid && n < MAX_TRIES + 2) begin
      tick();
      n++;
    end
    if (!rnd_valid) check("rnd_valid_timeout", 0, 1);
    r = rnd_out;
  endtask

  task automatic release_result();
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;
    check("release_valid", rnd_valid, 0);
    check("release_ready", req_ready, 1);
  endtask

  task automatic load(input logic [9:0] v);
    seed_load = 1'b1;
    seed      = v;
    tick();
    seed_load = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    int n, er, en_n, es, s, m, sel;
    bit lk, en_b, ld_b;

    vecs.push_back(mk(1, 0, 0, 10'h000, 10'h000, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h200, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h300, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h380, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h3C0, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h3E0, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h3F0, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h3F8, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h1FC, 0));
    vecs.push_back(mk(1, 1, 0, 10'h000, 10'h000, 0));
    vecs.push_back(mk(0, 0, 1, 10'h155, 10'h155, 0));
    vecs.push_back(mk(0, 0, 0, 10'h000, 10'h155, 0));
    vecs.push_back(mk(0, 0, 0, 10'h000, 10'h155, 0));
    vecs.push_back(mk(0, 0, 1, 10'h3FF, 10'h3FF, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h000, 1));
    vecs.push_back(mk(0, 0, 0, 10'h000, 10'h000, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h200, 0));
    vecs.push_back(mk(0, 1, 1, 10'h3FF, 10'h3FF, 0));
    vecs.push_back(mk(0, 1, 1, 10'h0AA, 10'h0AA, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h055, 0));

    tick();
    check("reset_state", state, 0);
    check("reset_lockup", lockup, 0);
    check("reset_rnd_valid", rnd_valid, 0);
    check("reset_rnd_out", rnd_out, 0);
    check("reset_req_ready", req_ready, 1);

    foreach (vecs[i]) begin
      Reset = vecs[i].rst; enable = vecs[i].en; seed_load = vecs[i].ld; seed = vecs[i].sd;
      tick();
      check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
      check($sformatf("vec%0d_lockup", i), lockup, vecs[i].exp_lock);
    end
    Reset = 1'b0; enable = 1'b0; seed_load = 1'b0;

    // First request from the reset state: candidate 0 accepted on the first try.
    Reset = 1'b1; tick(); Reset = 1'b0;
    do_request(8'd5, r, n);
    check("first_rnd_out", r, 0);
    check("first_latency", n, 1);
    check("first_state", state, 10'h200);
    release_result();

    // Every candidate rejected: fallback after MAX_TRIES samples; max_val wiggled mid-request.
    load(10'h0FF);
    do_request(8'd2, r, n);
    model_range(10'h0FF, 2, er, en_n, es);
    check("fallback_rnd_out", r, 1);
    check("fallback_latency", n, 4);
    check("fallback_state", state, es);

    // Result pending, consumer stalled, then Reset wipes it.
    for (int i = 0; i < 5; i++) tick();
    check("hold_valid", rnd_valid, 1);
    check("hold_rnd_out", rnd_out, 1);
    check("hold_ready", req_ready, 0);
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("hold_reset_valid", rnd_valid, 0);
    check("hold_reset_ready", req_ready, 1);
    check("hold_reset_state", state, 0);
    check("hold_reset_rnd_out", rnd_out, 0);

    load(10'h1FF);
    do_request(8'd0, r, n);
    check("max0_rnd_out", r, 0);
    check("max0_latency", n, 1);
    release_result();

    load(10'h2A5);
    do_request(8'hFF, r, n);
    check("maxff_rnd_out", r, 8'hA5);
    check("maxff_latency", n, 1);
    release_result();

    // Randomized requests against the transaction model.
    for (int it = 0; it < 40; it++) begin
      s = $urandom_range(0, ALL1);
      sel = $urandom_range(0, 3);
      m = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(0, 255);
      load(10'(s));
      s = step(s, 0, lk);
      model_range(s, m, er, en_n, es);
      do_request(8'(m), r, n);
      check($sformatf("rand%0d_rnd_out", it), r, er);
      check($sformatf("rand%0d_bound", it), (r <= 8'(m)), 1);
      check($sformatf("rand%0d_latency", it), n, en_n);
      check($sformatf("rand%0d_state", it), state, es);
      release_result();
    end

    // Randomized free-running with occasional seed loads, some of them all-ones.
    Reset = 1'b1; tick(); Reset = 1'b0;
    s = 0;
    for (int c = 0; c < 80; c++) begin
      en_b = ($urandom_range(0, 3) != 0);
      ld_b = ($urandom_range(0, 7) == 0);
      enable = en_b;
      seed_load = ld_b;
      seed = ($urandom_range(0, 1) == 0) ? 10'h3FF : 10'($urandom_range(0, ALL1));
      if (ld_b) begin
        s = seed;
        lk = 0;
      end else begin
        s = step(s, en_b, lk);
      end
      tick();
      check($sformatf("run%0d_state", c), state, s);
      check($sformatf("run%0d_lockup", c), lockup, lk);
    end
    enable = 1'b0;
    seed_load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
